// File: rtl/noise_generator_lfsr.sv
// Noise source for the waveform mixer: 23-bit Fibonacci LFSR (taps 22, 17) with an
// 8-bit SID-style output tap pattern. Adds output width scaling, step qualification
// (edge or level), test hold, runtime seed load and all-zero lockup recovery.
module noise_generator_lfsr #(
  parameter int unsigned OUT_WIDTH = 12,
  parameter logic [22:0] SEED      = 23'h37242B,
  parameter bit          STEP_EDGE = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 step_i,
  input  logic                 test_i,
  input  logic                 load_i,
  input  logic [22:0]          seed_i,
  output logic [OUT_WIDTH-1:0] dout_o,
  output logic                 lockup_o
);

  // Taps are MSB-aligned: a wide output gets zero padding below, a narrow output
  // keeps only the top OUT_WIDTH taps. Both fall out of slicing the top of a
  // zero-extended vector.
  function automatic logic [OUT_WIDTH-1:0] map_taps(input logic [22:0] x);
    logic [7:0]           t;
    logic [OUT_WIDTH+7:0] wide;
    t    = {x[22], x[20], x[16], x[13], x[11], x[7], x[4], x[2]};
    wide = '0;
    wide[OUT_WIDTH+7 -: 8] = t;
    return wide[OUT_WIDTH+7:8];
  endfunction

  localparam logic [OUT_WIDTH-1:0] DoutRst = map_taps(SEED);

  logic [22:0] lfsr_q, lfsr_d;
  logic [22:0] lfsr_shift;
  logic        step_q;
  logic        adv;
  logic        lockup_d;

  assign lfsr_shift = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};

  // Qualify the oscillator bit: rising edge in edge mode, raw level otherwise.
  always_comb begin
    adv = step_i;
    if (STEP_EDGE) begin
      adv = step_i & ~step_q;
    end
  end

  // Next LFSR state; test beats load beats lockup recovery beats a shift.
  always_comb begin
    lfsr_d   = lfsr_q;
    lockup_d = 1'b0;
    if (test_i) begin
      lfsr_d = SEED;
    end else if (load_i) begin
      lfsr_d = seed_i;
    end else if (lfsr_q == '0) begin
      lfsr_d   = SEED;
      lockup_d = 1'b1;
    end else if (adv) begin
      lfsr_d = lfsr_shift;
    end
  end

  // State and registered outputs; dout always samples the pre-update LFSR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q   <= SEED;
      step_q   <= 1'b0;
      lockup_o <= 1'b0;
      dout_o   <= DoutRst;
    end else begin
      lfsr_q   <= lfsr_d;
      step_q   <= step_i;
      lockup_o <= lockup_d;
      dout_o   <= map_taps(lfsr_q);
    end
  end

endmodule

// File: tb/tb_noise_generator_lfsr.sv
// Bench for noise_generator_lfsr: four instances (edge/12, level/12, edge/4,
// edge/16) share all inputs; directed hand-computed checks plus a per-cycle model.
module tb_noise_generator_lfsr;

  localparam logic [22:0] SEED = 23'h37242B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic        test = 1'b0;
  logic        load = 1'b0;
  logic [22:0] seed = '0;

  logic [11:0] dout_e, dout_l;
  logic [3:0]  dout_w4;
  logic [15:0] dout_w16;
  logic        lock_e, lock_l, lock_w4, lock_w16;

  int checks = 0;
  int failures = 0;

  // Model state: edge-mode LFSR (shared by the 12/4/16 edge instances) and level-mode LFSR.
  logic [22:0] me, ml;
  logic        sde;
  logic [7:0]  xe_taps, xl_taps;
  logic        xe_lock, xl_lock;

  always #5 clk = ~clk;

  noise_generator_lfsr #(.OUT_WIDTH(12), .SEED(SEED), .STEP_EDGE(1'b1)) u_edge (
    .clk_i(clk), .rst_i(rst), .step_i(step), .test_i(test), .load_i(load), .seed_i(seed),
    .dout_o(dout_e), .lockup_o(lock_e)
  );
  noise_generator_lfsr #(.OUT_WIDTH(12), .SEED(SEED), .STEP_EDGE(1'b0)) u_level (
    .clk_i(clk), .rst_i(rst), .step_i(step), .test_i(test), .load_i(load), .seed_i(seed),
    .dout_o(dout_l), .lockup_o(lock_l)
  );
  noise_generator_lfsr #(.OUT_WIDTH(4), .SEED(SEED), .STEP_EDGE(1'b1)) u_w4 (
    .clk_i(clk), .rst_i(rst), .step_i(step), .test_i(test), .load_i(load), .seed_i(seed),
    .dout_o(dout_w4), .lockup_o(lock_w4)
  );
  noise_generator_lfsr #(.OUT_WIDTH(16), .SEED(SEED), .STEP_EDGE(1'b1)) u_w16 (
    .clk_i(clk), .rst_i(rst), .step_i(step), .test_i(test), .load_i(load), .seed_i(seed),
    .dout_o(dout_w16), .lockup_o(lock_w16)
  );

  function automatic logic [7:0] taps(input logic [22:0] x);
    return {x[22], x[20], x[16], x[13], x[11], x[7], x[4], x[2]};
  endfunction

  function automatic logic [22:0] mnext(input logic [22:0] x, input logic adv,
                                        input logic t, input logic l, input logic [22:0] s);
    if (t) return SEED;
    if (l) return s;
    if (x == 23'd0) return SEED;
    if (adv) return {x[21:0], x[22] ^ x[17]};
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    me      = SEED;
    ml      = SEED;
    sde     = 1'b0;
    xe_taps = taps(SEED);
    xl_taps = taps(SEED);
    xe_lock = 1'b0;
    xl_lock = 1'b0;
  endtask

  // One clock: predict from the inputs applied now, then compare all instances.
  task automatic tick();
    logic [22:0] ne, nl;
    logic        le, ll;
    ne = mnext(me, step & ~sde, test, load, seed);
    nl = mnext(ml, step, test, load, seed);
    le = !test && !load && (me == 23'd0);
    ll = !test && !load && (ml == 23'd0);
    @(posedge clk);
    #1;
    xe_taps = taps(me);
    xl_taps = taps(ml);
    me      = ne;
    ml      = nl;
    xe_lock = le;
    xl_lock = ll;
    sde     = step;
    check("dout_edge",  32'(dout_e),   32'({xe_taps, 4'h0}));
    check("lock_edge",  32'(lock_e),   32'(xe_lock));
    check("dout_level", 32'(dout_l),   32'({xl_taps, 4'h0}));
    check("lock_level", 32'(lock_l),   32'(xl_lock));
    check("dout_w4",    32'(dout_w4),  32'(xe_taps[7:4]));
    check("lock_w4",    32'(lock_w4),  32'(xe_lock));
    check("dout_w16",   32'(dout_w16), 32'({xe_taps, 8'h00}));
    check("lock_w16",   32'(lock_w16), 32'(xe_lock));
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_dout_e",   32'(dout_e),   32'h700);
    check("rst_lock_e",   32'(lock_e),   32'h0);
    check("rst_dout_l",   32'(dout_l),   32'h700);
    check("rst_dout_w4",  32'(dout_w4),  32'h7);
    check("rst_dout_w16", 32'(dout_w16), 32'h7000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Step held high 20 cycles: one shift in edge mode, 20 in level mode.
    step = 1'b1;
    tick();
    check("pulse_lat", 32'(dout_e), 32'h700);
    tick();
    check("pulse_out", 32'(dout_e), 32'h8B0);
    repeat (18) tick();
    check("hold_one_shift", 32'(dout_e), 32'h8B0);

    // Toggle every cycle: one edge-mode shift per two cycles.
    for (int i = 0; i < 8; i++) begin
      step = ~step;
      tick();
    end

    // Test hold for 3 cycles while step toggles.
    test = 1'b1;
    step = 1'b0; tick();
    step = 1'b1; tick();
    check("test_seed", 32'(dout_e), 32'h700);
    step = 1'b0; tick();
    check("test_hold", 32'(dout_e), 32'h700);
    // Edge coincident with test release is honoured and shifts from SEED.
    test = 1'b0;
    step = 1'b1; tick();
    step = 1'b0; tick();
    check("test_restart", 32'(dout_e), 32'h8B0);

    // Load of 1 with a coincident edge: load wins; then 1 -> 2 -> 4.
    step = 1'b0; tick();
    load = 1'b1; seed = 23'h000001; step = 1'b1; tick();
    load = 1'b0; step = 1'b0; tick();
    check("load_one", 32'(dout_e), 32'h000);
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1; tick();
    step = 1'b0; tick();
    check("load_shift4", 32'(dout_e), 32'h010);
    check("load_shift4_w16", 32'(dout_w16), 32'h0100);

    // Load of zero: recovery with a single-cycle lockup pulse.
    load = 1'b1; seed = 23'h0; tick();
    check("zero_no_lock", 32'(lock_e), 32'h0);
    load = 1'b0; tick();
    check("zero_lock", 32'(lock_e), 32'h1);
    check("zero_dout", 32'(dout_e), 32'h000);
    tick();
    check("zero_lock_off", 32'(lock_e), 32'h0);
    check("zero_recover", 32'(dout_e), 32'h700);

    // Reset mid-stream with step high; first cycle after release is an edge.
    for (int i = 0; i < 5; i++) begin
      step = ~step;
      tick();
    end
    step = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_dout", 32'(dout_e), 32'h700);
    check("midrst_lock", 32'(lock_e), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    check("midrst_edge", 32'(dout_e), 32'h8B0);

    // Random stream against the model, with occasional test/load.
    for (int i = 0; i < 1000; i++) begin
      step = 1'($urandom_range(0, 1));
      test = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 31) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
      tick();
    end
    test = 1'b0;
    load = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
